// File: rtl/cn_serial_minsum_ctrl_if.sv
// Handshake bundle for the serial min-sum check-node controller:
// variable-to-check input stream and check-to-variable output stream.
interface cn_serial_minsum_ctrl_if #(
  parameter int W     = 16,
  parameter int DEG_W = 4
);
  logic [DEG_W-1:0] deg_cfg;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_msg;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_msg;
  logic [DEG_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  modport master (
    output deg_cfg,
    output in_valid,
    output in_msg,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_msg,
    input  out_idx,
    input  out_last,
    input  busy
  );

  modport slave (
    input  deg_cfg,
    input  in_valid,
    input  in_msg,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_msg,
    output out_idx,
    output out_last,
    output busy
  );
endinterface

// File: rtl/cn_serial_minsum_ctrl.sv
// Time-shared min-sum check node: collects deg messages, then emits deg
// extrinsic replies in input order. Define CN_OFFSET_EN for offset min-sum.
module cn_serial_minsum_ctrl #(
  parameter int INT     = 8,
  parameter int FRAC    = 8,
  parameter int MAX_DEG = 8,
  parameter int DEG_W   = 4,
  parameter logic [INT+FRAC-1:0] OFFSET = 16'h0080
) (
  input logic clk,
  input logic rst_n,
  cn_serial_minsum_ctrl_if.slave bus
);
  localparam int W = INT + FRAC;
  localparam int NSGN = 1 << DEG_W;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [DEG_W-1:0] ONE = DEG_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;

  state_t state;

  logic [DEG_W-1:0] deg;
  logic [DEG_W-1:0] cnt;
  logic [DEG_W-1:0] min1_idx;
  logic [DEG_W-1:0] out_idx;
  logic [W-1:0]     min1;
  logic [W-1:0]     min2;
  logic [NSGN-1:0]  sign;
  logic             sign_prod;
  logic             in_ready;
  logic             out_valid;
  logic             out_last;
  logic             busy;

  logic             in_fire;
  logic             out_fire;
  logic [W-1:0]     in_abs;
  logic [DEG_W-1:0] deg_clamp;
  logic [W-1:0]     mag_raw;
  logic [W-1:0]     mag;
  logic             s_out;
  logic [W-1:0]     msg_c;

  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;

  // Most negative input has no positive twin; pin it to max positive.
  always_comb begin
    in_abs = bus.in_msg;
    if (bus.in_msg[W-1]) begin
      if (bus.in_msg == MOST_NEG) in_abs = MAX_POS;
      else                        in_abs = -bus.in_msg;
    end
  end

  always_comb begin
    deg_clamp = bus.deg_cfg;
    if (bus.deg_cfg < DEG_W'(2))
      deg_clamp = DEG_W'(2);
    else if (bus.deg_cfg > DEG_W'(MAX_DEG))
      deg_clamp = DEG_W'(MAX_DEG);
  end

  always_comb begin
    mag_raw = (out_idx == min1_idx) ? min2 : min1;
`ifdef CN_OFFSET_EN
    mag = (mag_raw > OFFSET) ? mag_raw - OFFSET : '0;
`else
    mag = mag_raw;
`endif
    s_out = sign_prod ^ sign[out_idx];
    msg_c = s_out ? -mag : mag;
  end

`ifndef CN_OFFSET_EN
  logic unused_offset;
  assign unused_offset = ^OFFSET;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      deg       <= DEG_W'(2);
      cnt       <= '0;
      min1      <= MAX_POS;
      min2      <= MAX_POS;
      min1_idx  <= '0;
      sign      <= '0;
      sign_prod <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            deg   <= deg_clamp;
            cnt   <= ONE;
            busy  <= 1'b1;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (in_fire) begin
            cnt <= cnt + ONE;
            if (cnt == deg - ONE) begin
              state     <= EMIT;
              cnt       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_idx   <= '0;
              out_last  <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            out_idx  <= out_idx + ONE;
            out_last <= (out_idx + ONE == deg - ONE);
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              min1      <= MAX_POS;
              min2      <= MAX_POS;
              min1_idx  <= '0;
              sign_prod <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Ties with min1 fall through to min2.
      if (in_fire) begin
        sign[cnt] <= bus.in_msg[W-1];
        sign_prod <= sign_prod ^ bus.in_msg[W-1];
        if (in_abs < min1) begin
          min2     <= min1;
          min1     <= in_abs;
          min1_idx <= cnt;
        end else if (in_abs < min2) begin
          min2 <= in_abs;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_msg   = out_valid ? msg_c : '0;
  assign bus.out_idx   = out_idx;
  assign bus.out_last  = out_last;
  assign bus.busy      = busy;

endmodule
